// File: rtl/mem_channel_arbiter_if.sv
// Channel-side request/response bundle for mem_channel_arbiter.
// The master drives requests; the slave (arbiter) returns ready pulses and read data.
interface mem_channel_arbiter_if #(
  parameter int NUM_CHANNELS = 16,
  parameter int ADDR_BITS    = 12,
  parameter int DATA_BITS    = 16
);
  logic [NUM_CHANNELS-1:0] mem_read_valid;
  logic [ADDR_BITS-1:0]    mem_read_address  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_read_ready;
  logic [DATA_BITS-1:0]    mem_read_data     [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_valid;
  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS];
  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready
  );
endinterface

// File: rtl/mem_channel_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_CHANNELS requesters.
// One transaction in flight; writes win over reads on the same channel.
module mem_channel_arbiter #(
  parameter int NUM_CHANNELS = 16,
  parameter int ADDR_BITS    = 12,
  parameter int DATA_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_channel_arbiter_if.slave ch,
  output logic                 sram_en,
  output logic                 sram_we,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_wdata,
  input  logic [DATA_BITS-1:0] sram_rdata,
  output logic                 busy
);
  localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, RESPOND} state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           rr_ptr, grant, pick;
  logic                    op_wr, pick_wr, found;
  logic [ADDR_BITS-1:0]    addr_q;
  logic [DATA_BITS-1:0]    wdata_q;
  logic [DATA_BITS-1:0]    rdata_q [NUM_CHANNELS];
  // Served flags are tracked per op so a channel holding both valids
  // still gets its read after the write, yet neither op repeats while held.
  logic [NUM_CHANNELS-1:0] served_wr, served_rd, elig_wr, elig_rd, active;

  assign active  = ch.mem_read_valid | ch.mem_write_valid;
  assign elig_wr = ch.mem_write_valid & ~served_wr;
  assign elig_rd = ch.mem_read_valid & ~served_rd;

  always_comb begin
    logic [CW:0] s;
    logic [CW-1:0] idx;
    found   = 1'b0;
    pick    = '0;
    pick_wr = 1'b0;
    s       = '0;
    idx     = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      s = {1'b0, rr_ptr} + (CW+1)'(i);
      if (s >= (CW+1)'(NUM_CHANNELS)) s = s - (CW+1)'(NUM_CHANNELS);
      idx = s[CW-1:0];
      if (!found && (elig_wr[idx] || elig_rd[idx])) begin
        found   = 1'b1;
        pick    = idx;
        pick_wr = elig_wr[idx];
      end
    end
  end

  always_comb begin
    state_n            = state;
    sram_en            = 1'b0;
    sram_we            = 1'b0;
    busy               = (state != IDLE);
    ch.mem_read_ready  = '0;
    ch.mem_write_ready = '0;
    unique case (state)
      IDLE:    if (found) state_n = ISSUE;
      ISSUE: begin
        sram_en = 1'b1;
        sram_we = op_wr;
        state_n = op_wr ? RESPOND : RWAIT;
      end
      RWAIT:   state_n = RESPOND;
      RESPOND: begin
        if (op_wr) ch.mem_write_ready = NUM_CHANNELS'(1) << grant;
        else       ch.mem_read_ready  = NUM_CHANNELS'(1) << grant;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) ch.mem_read_data[c] = rdata_q[c];
  end

  assign sram_addr  = addr_q;
  assign sram_wdata = wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      op_wr     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      served_wr <= '0;
      served_rd <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) rdata_q[c] <= '0;
    end else begin
      state <= state_n;
      // Operands are latched at grant; later changes on the bus are ignored.
      if (state == IDLE && found) begin
        grant  <= pick;
        op_wr  <= pick_wr;
        rr_ptr <= (pick == CW'(NUM_CHANNELS-1)) ? '0 : pick + 1'b1;
        if (pick_wr) begin
          addr_q  <= ch.mem_write_address[pick];
          wdata_q <= ch.mem_write_data[pick];
        end else begin
          addr_q  <= ch.mem_read_address[pick];
        end
      end
      if (state == RWAIT) rdata_q[grant] <= sram_rdata;
      // Clearing on idle valids wins over the set from a same-cycle ready.
      served_wr <= (served_wr | ch.mem_write_ready) & active;
      served_rd <= (served_rd | ch.mem_read_ready) & active;
    end
  end
endmodule

// File: doc/mem_channel_arbiter.md
MEM_CHANNEL_ARBITER -- requirements
Module: mem_channel_arbiter

Interface
REQ-001 Parameter NUM_CHANNELS, default 16, SHALL set the number of GPU data-memory channels served.
REQ-002 Parameter ADDR_BITS, default 12, SHALL set the memory address width.
REQ-003 Parameter DATA_BITS, default 16, SHALL set the memory word width (Q1.15).
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 mem_read_valid  input  NUM_CHANNELS  SHALL carry the per-channel read request.
REQ-007 mem_read_address  input  ADDR_BITS x NUM_CHANNELS (unpacked)  SHALL carry the per-channel read address.
REQ-008 mem_read_ready  output  NUM_CHANNELS  SHALL signal per-channel read completion.
REQ-009 mem_read_data  output  DATA_BITS x NUM_CHANNELS (unpacked)  SHALL carry the per-channel read data.
REQ-010 mem_write_valid  input  NUM_CHANNELS  SHALL carry the per-channel write request.
REQ-011 mem_write_address  input  ADDR_BITS x NUM_CHANNELS  SHALL carry the per-channel write address.
REQ-012 mem_write_data  input  DATA_BITS x NUM_CHANNELS  SHALL carry the per-channel write data.
REQ-013 mem_write_ready  output  NUM_CHANNELS  SHALL signal per-channel write completion.
REQ-014 sram_en, sram_we  output  1 each  SHALL be the single-port SRAM enable and write strobe.
REQ-015 sram_addr  output  ADDR_BITS; sram_wdata  output  DATA_BITS; sram_rdata  input  DATA_BITS; SRAM read latency SHALL be 1 cycle.
REQ-016 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RWAIT, RESPOND.
REQ-018 IDLE: eligible channel = (read_valid|write_valid) and served flag clear; if any, register grant channel and op, go ISSUE; else stay.
REQ-019 Arbitration SHALL be round-robin: search starts at rr_ptr, wrapping NUM_CHANNELS-1 -> 0; after grant to k, rr_ptr = (k+1) mod NUM_CHANNELS.
REQ-020 If a channel has read_valid and write_valid together, the write SHALL be served first; the read is then served on a later grant.
REQ-021 ISSUE: sram_en=1, sram_addr = granted address; write: sram_we=1, sram_wdata = granted data, next RESPOND; read: sram_we=0, next RWAIT.
REQ-022 RWAIT: capture sram_rdata into mem_read_data[grant], next RESPOND.
REQ-023 RESPOND: assert exactly one of mem_read_ready[grant]/mem_write_ready[grant] for exactly one cycle, set served[grant], return IDLE.
REQ-024 Latency from grant registration: write ready 2 cycles later, read ready 3 cycles later; max 1 request in flight.
REQ-025 served[ch] SHALL clear in any cycle where both valids of ch are low; a served channel SHALL NOT be re-granted while its valid is held.
REQ-026 mem_read_data[ch] SHALL hold its last value until the next read to ch completes.
REQ-027 Request operands SHALL be sampled in IDLE at grant; changes afterwards SHALL NOT affect the transaction.
REQ-028 Outside ISSUE, sram_en and sram_we SHALL be 0.

Reset
REQ-029 On reset low, asynchronously: FSM=IDLE, rr_ptr=0, served=0, all ready=0, all read_data=0, sram_en=sram_we=0, sram_addr=sram_wdata=0, busy=0.
REQ-030 Reset mid-transaction SHALL abort it with no ready asserted; an aborted write that reached ISSUE MAY have updated SRAM.
REQ-031 After release, the first grant SHALL be evaluated on the first rising edge with reset high.

Verification
REQ-032 Write ch3 addr 0x010 data 0x4000, then read ch3 addr 0x010 -> write_ready[3] one cycle at +2, read_ready[3] at +3 with data 0x4000.
REQ-033 Channels 0,5,15 raise read together with rr_ptr=0 -> grant order 0,5,15; next round with all 16 pending starts at 0 (wrap).
REQ-034 Channel 7 holds read_valid 4 cycles after ready -> exactly one ready pulse, SRAM accessed once; drop and re-raise -> second service.
REQ-035 Channel 2 raises read and write simultaneously (addr 0x020, data 0x1234) -> write served first, later read returns 0x1234.
REQ-036 Reset asserted during RWAIT -> no read_ready, all outputs zero, busy=0; fresh request after release completes normally.
